noc_packet_gen: RTL

- Per-node traffic source that builds 40-bit packets and injects them into the local port of its mesh router.
- Driven by the per-node task controls at noc_top level: send count, injection rate, destination sequence, mode, debug select and flush.
- Raises the per-node send-finish flag once every packet has been accepted.
- One instance per node of the 3x3 mesh, directly upstream of the router local input.

---
 rtl/noc_pkg.sv | 44 ++++
 rtl/noc_lfsr16.sv | 29 ++
 rtl/noc_packet_gen.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the mesh traffic generator:
// flit field positions, TYPE/mode encodings, FSM states.
package noc_pkg;

  localparam int NUM_NODES = 9;
  localparam int FLIT_W    = 40;

  localparam int SRC_HI  = 39;
  localparam int SRC_LO  = 36;
  localparam int DST_HI  = 35;
  localparam int DST_LO  = 32;
  localparam int TIME_HI = 31;
  localparam int TIME_LO = 22;
  localparam int DATA_HI = 21;
  localparam int DATA_LO = 2;
  localparam int TYPE_HI = 1;
  localparam int TYPE_LO = 0;

  typedef enum logic [1:0] {
    TYPE_NORMAL = 2'b00,
    TYPE_DEBUG  = 2'b01
  } pkt_type_e;

  typedef enum logic [3:0] {
    MODE_SEQ = 4'b0000,
    MODE_REV = 4'b0001
  } gen_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } gen_state_e;

  function automatic logic [3:0] next_idx(
    input logic [3:0] i
  );
    if (int'(i) >= NUM_NODES - 1) return 4'd0;
    return i + 4'd1;
  endfunction

endpackage

// File: rtl/noc_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), one step per step_i.
// Ports: clk, rst_n (async, active-low), step_i, lfsr_o (current state).
module noc_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  // Right-shifting form: taps 16,14,13,11 sit at bits 0,2,3,5.
  always_comb begin
    fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d = step_i ? {fb, lfsr_q[15:1]} : lfsr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/noc_packet_gen.sv
// Per-node packet source feeding the router local port.
// Ports: task controls in, out_flit/out_valid/out_ready handshake,
// task_send_finish_flag and sent_count status out.
module noc_packet_gen
  import noc_pkg::*;
#(
  parameter int          NODE_ID   = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              dbg_mode,
  input  logic [3:0]        send_num,
  input  logic [3:0]        rate,
  input  logic [35:0]       dst_seq,
  input  logic [3:0]        mode,
  input  logic              flush,
  input  logic [9:0]        cur_time,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              task_send_finish_flag,
  output logic [3:0]        sent_count
);

  localparam logic [3:0] NODE    = 4'(NODE_ID);
  localparam logic [3:0] REV_DST = 4'(8 - NODE_ID);

  gen_state_e        state_q, state_d;
  logic              en_q;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic              valid_q, valid_d;
  logic              flag_q, flag_d;
  logic [3:0]        sent_q, sent_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        scan_q, scan_d;
  logic [3:0]        gap_q, gap_d;

  logic [15:0]       lfsr;
  logic              lfsr_step;
  logic [5:0]        ent_hi;
  logic [3:0]        entry;
  logic              rev;
  logic              pick_ok;
  logic              xfer;
  logic              last;
  logic              gap_end;
  logic [FLIT_W-1:0] pkt;

  noc_lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step_i(lfsr_step),
    .lfsr_o(lfsr)
  );

  always_comb begin
    ent_hi  = 6'd35 - {idx_q, 2'b00};
    entry   = dst_seq[ent_hi -: 4];
    rev     = (mode == MODE_REV);
    // Reverse mode has one fixed target; node 4 maps onto itself.
    pick_ok = rev ? (REV_DST != NODE)
                  : (entry <= 4'd8 && entry != NODE);
    xfer    = valid_q & out_ready;
    last    = (sent_q + 4'd1 == send_num);
    gap_end = ({1'b0, gap_q} + 5'd1 >= {1'b0, rate});
  end

  always_comb begin
    pkt = '0;
    pkt[SRC_HI:SRC_LO]   = NODE;
    pkt[DST_HI:DST_LO]   = rev ? REV_DST : entry;
    pkt[TIME_HI:TIME_LO] = cur_time;
    pkt[DATA_HI:DATA_LO] = dbg_mode ? {16'h0, sent_q}
                                    : {4'h0, lfsr};
    pkt[TYPE_HI:TYPE_LO] = dbg_mode ? TYPE_DEBUG
                                    : TYPE_NORMAL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (en_q)
            state_d = (send_num == 4'd0) ? ST_DONE
                                         : ST_SELECT;
        end
        ST_SELECT: begin
          if (pick_ok)               state_d = ST_SEND;
          else if (rev)              state_d = ST_DONE;
          else if (scan_q == 4'd8)   state_d = ST_DONE;
        end
        ST_SEND: begin
          if (xfer) begin
            if (last)              state_d = ST_DONE;
            else if (rate == 4'd0) state_d = ST_SELECT;
            else                   state_d = ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_end) state_d = ST_SELECT;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    flit_d    = flit_q;
    valid_d   = valid_q;
    flag_d    = flag_q;
    sent_d    = sent_q;
    idx_d     = idx_q;
    scan_d    = scan_q;
    gap_d     = gap_q;
    lfsr_step = 1'b0;
    if (flush) begin
      valid_d = 1'b0;
      flag_d  = 1'b0;
      sent_d  = 4'd0;
      idx_d   = 4'd0;
      scan_d  = 4'd0;
      gap_d   = 4'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          scan_d = 4'd0;
          gap_d  = 4'd0;
          if (state_d == ST_DONE) flag_d = 1'b1;
        end
        ST_SELECT: begin
          if (state_d == ST_SEND) begin
            flit_d  = pkt;
            valid_d = 1'b1;
            scan_d  = 4'd0;
          end else if (state_d == ST_DONE) begin
            flag_d = 1'b1;
          end else begin
            idx_d  = next_idx(idx_q);
            scan_d = scan_q + 4'd1;
          end
        end
        ST_SEND: begin
          if (xfer) begin
            valid_d   = 1'b0;
            sent_d    = sent_q + 4'd1;
            idx_d     = next_idx(idx_q);
            gap_d     = 4'd0;
            lfsr_step = 1'b1;
            if (last) flag_d = 1'b1;
          end
        end
        ST_GAP:  gap_d  = gap_q + 4'd1;
        ST_DONE: flag_d = 1'b1;
        default: valid_d = 1'b0;
      endcase
    end
  end

  // enable is registered, so IDLE acts on it one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      flit_q  <= '0;
      valid_q <= 1'b0;
      flag_q  <= 1'b0;
      sent_q  <= 4'd0;
      idx_q   <= 4'd0;
      scan_q  <= 4'd0;
      gap_q   <= 4'd0;
    end else begin
      en_q    <= enable;
      flit_q  <= flit_d;
      valid_q <= valid_d;
      flag_q  <= flag_d;
      sent_q  <= sent_d;
      idx_q   <= idx_d;
      scan_q  <= scan_d;
      gap_q   <= gap_d;
    end
  end

  assign out_flit              = flit_q;
  assign out_valid             = valid_q;
  assign task_send_finish_flag = flag_q;
  assign sent_count            = sent_q;

endmodule
